// File: rtl/adat_bit_recovery.sv
// ADAT bit recovery: decodes the NRZI line into one bit per bit period, detects the
// sync pattern (ten zeros then a one) and tracks frame alignment and lock.
//
// Ports:
//   clk_i        oversampling clock, SAMPLES_PER_BIT cycles per ADAT bit
//   rst_i        synchronous active-high reset
//   signal_i     conditioned ADAT line, synchronous to clk_i
//   bit_o        decoded bit (1 = line transition within the bit period)
//   bit_valid_o  one-cycle strobe, bit_o valid
//   sync_o       with bit_valid_o on the '1' that ends an exact 10-zero run
//   bit_index_o  frame position of bit_o (sync '1' = 255, next bit = 0)
//   locked_o     high while frame alignment is locked
module adat_bit_recovery #(
    parameter int unsigned SAMPLES_PER_BIT = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       signal_i,
    output logic       bit_o,
    output logic       bit_valid_o,
    output logic       sync_o,
    output logic [7:0] bit_index_o,
    output logic       locked_o
);

    localparam int unsigned PhaseW = $clog2(SAMPLES_PER_BIT);
    localparam logic [PhaseW-1:0] PhaseLast   = PhaseW'(SAMPLES_PER_BIT - 1);
    localparam logic [PhaseW-1:0] PhaseSample = PhaseW'(SAMPLES_PER_BIT / 2);

    typedef enum logic [1:0] {StUnlocked, StCandidate, StLocked} state_e;

    logic              signal_q;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic              pending_q, pending_d;
    logic [3:0]        zero_run_q, zero_run_d;
    logic [7:0]        idx_q, idx_d;
    state_e            state_q, state_d;

    logic trans;
    logic emit;
    logic is_sync;
    logic is_loss;
    logic at_frame_end;
    logic locked_d;

    always_comb begin
        trans        = signal_i ^ signal_q;
        // A transition landing on the sample point suppresses it; the period realigns.
        emit         = (phase_q == PhaseSample) && !trans;
        is_sync      = emit && pending_q && (zero_run_q == 4'd10);
        is_loss      = emit && !pending_q && (zero_run_q == 4'd10);
        at_frame_end = (idx_q == 8'hFF);
    end

    always_comb begin
        phase_d    = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
        pending_d  = pending_q;
        zero_run_d = zero_run_q;
        idx_d      = idx_q;
        if (trans) begin
            phase_d   = '0;
            pending_d = 1'b1;
        end else if (emit) begin
            pending_d = 1'b0;
        end
        if (emit) begin
            if (pending_q) begin
                zero_run_d = '0;
            end else if (zero_run_q != 4'hF) begin
                zero_run_d = zero_run_q + 1'b1;
            end
            idx_d = is_sync ? 8'h00 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            signal_q   <= 1'b0;
            phase_q    <= '0;
            pending_q  <= 1'b0;
            zero_run_q <= '0;
            idx_q      <= '0;
        end else begin
            signal_q   <= signal_i;
            phase_q    <= phase_d;
            pending_q  <= pending_d;
            zero_run_q <= zero_run_d;
            idx_q      <= idx_d;
        end
    end

    // Lock FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StUnlocked;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock FSM: next state, only evaluated on emitted bits; loss wins over everything
    always_comb begin
        state_d = state_q;
        if (emit) begin
            if (is_loss) begin
                state_d = StUnlocked;
            end else begin
                unique case (state_q)
                    StUnlocked:  if (is_sync) state_d = StCandidate;
                    StCandidate: if (is_sync && at_frame_end) state_d = StLocked;
                    // Sync off position, or no sync where one was due
                    StLocked:    if (is_sync != at_frame_end) state_d = StCandidate;
                    default:     state_d = StUnlocked;
                endcase
            end
        end
    end

    // Lock FSM: output decode
    always_comb begin
        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_o       <= 1'b0;
            bit_valid_o <= 1'b0;
            sync_o      <= 1'b0;
            bit_index_o <= 8'h00;
            locked_o    <= 1'b0;
        end else begin
            bit_valid_o <= emit;
            sync_o      <= is_sync;
            locked_o    <= locked_d;
            if (emit) begin
                bit_o       <= pending_q;
                bit_index_o <= is_sync ? 8'hFF : idx_q;
            end
        end
    end

endmodule

// File: doc/adat_bit_recovery.md
# adat_bit_recovery

Recovers the NRZI-coded ADAT bitstream from the oversampled, conditioned optical input line. It emits one decoded bit per bit period with a valid strobe, detects the ADAT sync pattern (10 zeros followed by a one), and tracks frame alignment and lock. It sits between the input conditioning stage (synchronizer plus zero-hold filter) and the ADAT frame deserializer.

## Interface
- SAMPLES_PER_BIT, 8, clk_i cycles per ADAT bit period; even, ≥4 (8 → 98.304 MHz clk_i for 12.288 Mbit/s)
- clk_i  input  1  system/oversampling clock; all logic on posedge
- rst_i  input  1  synchronous, active-high reset
- signal_i  input  1  conditioned ADAT line, already synchronous to clk_i
- bit_o  output  1  decoded bit (1 = line transition within bit period)
- bit_valid_o  output  1  one-cycle strobe, bit_o valid
- sync_o  output  1  high with bit_valid_o on the '1' that terminates a 10-zero run
- bit_index_o  output  8  frame position of bit_o; sync '1' = 255, next bit = 0
- locked_o  output  1  high while state is LOCKED

## Operation
- Edge detect: signal_r registers signal_i. A transition is any cycle where signal_i != signal_r.
- Phase counter phase_r, width $clog2(SAMPLES_PER_BIT):
  - On a transition cycle: phase_next = 0, pending_next = 1.
  - Otherwise: phase_r increments, wrapping from SAMPLES_PER_BIT-1 to 0.
- Sample point: when phase_r == SAMPLES_PER_BIT/2 and no transition in that cycle:
  - Emit a bit with bit = pending_r.
  - Clear pending_r.
- A transition in the sample cycle suppresses that sample. The period realigns.
- With no transitions, the free-running phase keeps emitting zeros at nominal rate.
- Zero run zero_run_r, 4-bit, saturating at 15:
  - A 0 increments it.
  - A 1 clears it.
- Sync: an emitted 1 while zero_run_r == 10. Runs other than exactly 10 are not sync.
- Loss: an emitted 0 that makes zero_run reach 11 forces UNLOCKED.
- Frame counter idx_r, 8-bit:
  - Increments per emitted bit, wrapping 255→0.
  - On sync, the emitted index is forced to 255 and idx_r becomes 0.
  - Otherwise the emitted index is the current idx_r.
- State machine (unlisted cases keep state; loss has priority):
  - UNLOCKED → CANDIDATE on sync.
  - CANDIDATE → LOCKED on sync when idx_r == 255 (expected position).
  - CANDIDATE stays CANDIDATE on sync elsewhere, realigning.
  - LOCKED → CANDIDATE on sync at an unexpected position.
  - LOCKED → CANDIDATE on a non-sync bit emitted at idx_r == 255.
  - Any state → UNLOCKED on loss.
- bit_index_o is driven in all states but meaningful only when locked_o = 1.

## Timing
- Reset (1 cycle suffices) sets these values:
  - bit_o = 0, bit_valid_o = 0, sync_o = 0, bit_index_o = 0, locked_o = 0.
  - signal_r = 0, phase_r = 0, pending_r = 0, zero_run_r = 0, idx_r = 0.
  - State = UNLOCKED.
- Reset mid-stream discards the partial bit. No strobe is issued in the reset cycle or the cycle after.
- All outputs are registered.
- Latency: signal_i transition first seen at cycle t → phase_r = 0 at t+1 → bit_valid_o with bit_o = 1 at t+2+SAMPLES_PER_BIT/2 (t+6 for default).
- bit_valid_o is never high in consecutive cycles. Nominal spacing is SAMPLES_PER_BIT cycles; a transition can shorten or stretch it by realignment.
- sync_o, bit_index_o and locked_o update in the same cycle as the corresponding bit_valid_o.
- locked_o changes only on bit_valid_o cycles.

## Test plan
- Reset, then hold signal_i = 0 for 200 cycles:
  - bit_valid_o pulses every 8 cycles with bit_o = 0.
  - The 11th zero leaves state UNLOCKED, locked_o = 0.
  - No sync_o.
- Single edge 0→1 at cycle t: bit_valid_o = 1, bit_o = 1 exactly at t+6; next strobes at t+14, t+22 with bit_o = 0.
- Ideal stream of two full frames (10 zeros, 1, then 245 bits with a 1 every 5th bit):
  - sync_o on each frame's sync '1' with bit_index_o = 255.
  - locked_o rises on the second sync.
- Locked stream, one frame's sync shifted by +1 bit: locked_o falls on the bit at index 255, then re-rises after two correctly spaced syncs.
- Bit-period jitter (run lengths of 7 and 9 cycles instead of 8, alternating) over 4 frames: decoded bits are identical to the ideal stream and locked_o stays 1.
- 9-zero and 11-zero runs before a 1: no sync_o; the 11-zero case forces locked_o = 0.
- rst_i asserted mid-frame while locked: all outputs are 0 the next cycle, and relock requires two syncs.
